game_controller: RTL and testbench



---
 rtl/game_controller.sv | 155 +++++++++++++++
 tb/tb_game_controller.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/game_controller.sv
// Number-guessing game sequencer: draws a secret from a free-running LFSR, then checks guesses and reports hints and win/lose.
// Optional GAME_SCORE_EN builds a saturating games-won counter on the score output.
module game_controller #(
    parameter int          ATTEMPTS  = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       restart,
    input  logic       start,
    input  logic [1:0] difficulty,
    input  logic       confirm,
    input  logic [3:0] compare_digit_1,
    input  logic [3:0] compare_digit_2,
    input  logic [3:0] compare_digit_3,
    output logic [1:0] max_digits,
    output logic [3:0] secret_digit_1,
    output logic [3:0] secret_digit_2,
    output logic [3:0] secret_digit_3,
    output logic [3:0] attempts_left,
    output logic       hint_high,
    output logic       hint_low,
    output logic       win,
    output logic       lose,
    output logic       busy,
    output logic [7:0] score
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        GEN   = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        WIN   = 3'd4,
        LOSE  = 3'd5
    } state_t;

    // An all-zero seed would lock the LFSR, so it is substituted.
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
    localparam logic [3:0]  ATT  = 4'(ATTEMPTS);

    state_t      state;
    logic [15:0] lfsr;
    logic        lfsr_fb;
    logic [9:0]  guess_val;
    logic [9:0]  secret_val;
    logic        guess_eq;
    logic [1:0]  diff_eff;

    function automatic logic [3:0] fold_digit(input logic [3:0] n);
        return (n >= 4'd10) ? (n - 4'd10) : n;
    endfunction

    assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    assign diff_eff = (difficulty == 2'd0) ? 2'd1 : difficulty;

    always_comb begin
        guess_val  = 10'(compare_digit_3) * 10'd100 + 10'(compare_digit_2) * 10'd10
                   + 10'(compare_digit_1);
        secret_val = 10'(secret_digit_3) * 10'd100 + 10'(secret_digit_2) * 10'd10
                   + 10'(secret_digit_1);
        guess_eq   = (guess_val == secret_val);
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr_fb};
        end
    end

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            state          <= IDLE;
            max_digits     <= 2'd0;
            secret_digit_1 <= 4'd0;
            secret_digit_2 <= 4'd0;
            secret_digit_3 <= 4'd0;
            attempts_left  <= 4'd0;
            hint_high      <= 1'b0;
            hint_low       <= 1'b0;
            win            <= 1'b0;
            lose           <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                IDLE, WIN, LOSE: begin
                    // start takes priority; confirm is never acted on here
                    if (start) begin
                        max_digits <= diff_eff;
                        busy       <= 1'b1;
                        state      <= GEN;
                    end
                end
                GEN: begin
                    secret_digit_1 <= fold_digit(lfsr[3:0]);
                    secret_digit_2 <= (max_digits >= 2'd2) ? fold_digit(lfsr[7:4]) : 4'd0;
                    secret_digit_3 <= (max_digits == 2'd3) ? fold_digit(lfsr[11:8]) : 4'd0;
                    attempts_left  <= ATT;
                    hint_high      <= 1'b0;
                    hint_low       <= 1'b0;
                    win            <= 1'b0;
                    lose           <= 1'b0;
                    state          <= PLAY;
                end
                PLAY: begin
                    if (confirm) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (guess_eq) begin
                        win       <= 1'b1;
                        hint_high <= 1'b0;
                        hint_low  <= 1'b0;
                        busy      <= 1'b0;
                        state     <= WIN;
                    end else begin
                        attempts_left <= attempts_left - 4'd1;
                        hint_high     <= (guess_val > secret_val);
                        hint_low      <= (guess_val < secret_val);
                        if (attempts_left == 4'd1) begin
                            lose  <= 1'b1;
                            busy  <= 1'b0;
                            state <= LOSE;
                        end else begin
                            state <= PLAY;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef GAME_SCORE_EN
    logic [7:0] score_q;

    always_ff @(posedge clk or negedge restart) begin
        if (!restart) begin
            score_q <= 8'd0;
        end else if (state == CHECK && guess_eq && score_q != 8'hFF) begin
            score_q <= score_q + 8'd1;
        end
    end

    assign score = score_q;
`else
    assign score = 8'd0;
`endif

endmodule

// File: tb/tb_game_controller.sv
// Self-checking bench for game_controller: an LFSR reference model predicts each secret, a guess model predicts hints and attempts.
module tb_game_controller;

    logic       clk;
    logic       restart;
    logic       start;
    logic [1:0] difficulty;
    logic       confirm;
    logic [3:0] compare_digit_1, compare_digit_2, compare_digit_3;
    logic [1:0] max_digits;
    logic [3:0] secret_digit_1, secret_digit_2, secret_digit_3;
    logic [3:0] attempts_left;
    logic       hint_high, hint_low, win, lose, busy;
    logic [7:0] score;

    int passed = 0;
    int total  = 0;

    logic [15:0] m_lfsr;
    logic [11:0] exp_q[$];
    int          sec_val;
    int          exp_att;
    int          exp_score = 0;
    logic [1:0]  exp_md;

    game_controller dut (
        .clk(clk), .restart(restart), .start(start), .difficulty(difficulty),
        .confirm(confirm), .compare_digit_1(compare_digit_1),
        .compare_digit_2(compare_digit_2), .compare_digit_3(compare_digit_3),
        .max_digits(max_digits), .secret_digit_1(secret_digit_1),
        .secret_digit_2(secret_digit_2), .secret_digit_3(secret_digit_3),
        .attempts_left(attempts_left), .hint_high(hint_high), .hint_low(hint_low),
        .win(win), .lose(lose), .busy(busy), .score(score)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference LFSR: taps 16,14,13,11, held at seed while restart is low
    always @(posedge clk or negedge restart) begin
        if (!restart) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [3:0] fold(input logic [3:0] n);
        return (n >= 4'd10) ? n - 4'd10 : n;
    endfunction

    function automatic int dig_val(input logic [11:0] d);
        return int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
    endfunction

    task automatic drive_digits(input int g);
        compare_digit_3 = 4'((g / 100) % 10);
        compare_digit_2 = 4'((g / 10) % 10);
        compare_digit_1 = 4'(g % 10);
    endtask

    // start a game and score the generated secret against the model
    task automatic start_game(input logic [1:0] diff);
        logic [11:0] e;
        logic [11:0] got;
        @(negedge clk);
        start = 1'b1; difficulty = diff;
        @(negedge clk);
        start = 1'b0;
        exp_md = (diff == 2'd0) ? 2'd1 : diff;
        total++;
        if (max_digits !== exp_md || busy !== 1'b1) begin
            $display("FAIL gen_entry max_digits=%0d busy=%b expected %0d/1", max_digits, busy, exp_md);
        end else passed++;
        e[3:0]  = fold(m_lfsr[3:0]);
        e[7:4]  = (exp_md >= 2'd2) ? fold(m_lfsr[7:4]) : 4'd0;
        e[11:8] = (exp_md == 2'd3) ? fold(m_lfsr[11:8]) : 4'd0;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        got = {secret_digit_3, secret_digit_2, secret_digit_1};
        total++;
        if (got !== e) $display("FAIL secret got=%h expected=%h", got, e);
        else passed++;
        total++;
        if (attempts_left !== 4'd7 || hint_high !== 1'b0 || hint_low !== 1'b0 ||
            win !== 1'b0 || lose !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL gen_init att=%0d hh=%b hl=%b win=%b lose=%b busy=%b expected 7/0/0/0/0/1",
                     attempts_left, hint_high, hint_low, win, lose, busy);
        end else passed++;
        sec_val = dig_val(e);
        exp_att = 7;
    endtask

    // confirm one guess and score {attempts, hint_high, hint_low, win, lose}
    task automatic do_guess(input int g, input string name);
        logic [7:0] e;
        logic [7:0] got;
        @(negedge clk);
        drive_digits(g);
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        if (g == sec_val) begin
            e = {4'(exp_att), 1'b0, 1'b0, 1'b1, 1'b0};
            exp_score = (exp_score < 255) ? exp_score + 1 : 255;
        end else begin
            exp_att = exp_att - 1;
            e = {4'(exp_att), g > sec_val, g < sec_val, 1'b0, exp_att == 0};
        end
        exp_q.push_back(e[7:0]);
        @(negedge clk);
        e = exp_q.pop_front();
        got = {attempts_left, hint_high, hint_low, win, lose};
        total++;
        if (got !== e) $display("FAIL %s got att/hh/hl/w/l=%b expected=%b", name, got, e);
        else passed++;
    endtask

    task automatic check_score(input string name);
        int es;
`ifdef GAME_SCORE_EN
        es = exp_score;
`else
        es = 0;
`endif
        total++;
        if (score !== 8'(es)) $display("FAIL %s score=%0d expected=%0d", name, score, es);
        else passed++;
    endtask

    task automatic test_reset;
        restart = 1'b0; start = 1'b0; confirm = 1'b0; difficulty = 2'd0;
        drive_digits(0);
        repeat (2) @(negedge clk);
        total++;
        if ({max_digits, secret_digit_1, secret_digit_2, secret_digit_3, attempts_left,
             hint_high, hint_low, win, lose, busy, score} !== 33'd0) begin
            $display("FAIL reset_outputs md=%0d att=%0d busy=%b score=%0d expected all 0",
                     max_digits, attempts_left, busy, score);
        end else passed++;
        restart = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (dut.lfsr === 16'h0 || dut.lfsr !== m_lfsr || max_digits !== 2'd0 ||
                busy !== 1'b0 || score !== 8'd0) begin
                $display("FAIL idle_hold cyc=%0d lfsr=%h model=%h md=%0d busy=%b score=%0d",
                         i, dut.lfsr, m_lfsr, max_digits, busy, score);
            end else passed++;
        end
    endtask

    task automatic test_easy_win;
        start_game(2'd0);
        total++;
        if (secret_digit_2 !== 4'd0 || secret_digit_3 !== 4'd0 || secret_digit_1 > 4'd9) begin
            $display("FAIL easy_digits d1=%0d d2=%0d d3=%0d expected d1<=9 d2=d3=0",
                     secret_digit_1, secret_digit_2, secret_digit_3);
        end else passed++;
        // start during PLAY must not restart the game
        @(negedge clk);
        start = 1'b1; difficulty = 2'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total++;
        if (max_digits !== 2'd1 || attempts_left !== 4'd7 || busy !== 1'b1) begin
            $display("FAIL start_in_play md=%0d att=%0d busy=%b expected 1/7/1",
                     max_digits, attempts_left, busy);
        end else passed++;
        do_guess(sec_val, "easy_win");
        check_score("score_after_win1");
        // confirm in WIN is ignored
        @(negedge clk);
        drive_digits((sec_val + 5) % 10);
        confirm = 1'b1;
        @(negedge clk);
        confirm = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (win !== 1'b1 || attempts_left !== 4'd7 || hint_high !== 1'b0 ||
            hint_low !== 1'b0 || busy !== 1'b0 || max_digits !== 2'd1) begin
            $display("FAIL confirm_in_win win=%b att=%0d hh=%b hl=%b busy=%b md=%0d expected 1/7/0/0/0/1",
                     win, attempts_left, hint_high, hint_low, busy, max_digits);
        end else passed++;
    endtask

    task automatic test_hints;
        start_game(2'd3);
        do_guess((sec_val == 999) ? 998 : 999, "guess_hi");
        do_guess((sec_val == 1) ? 0 : 1, "guess_lo");
        do_guess(sec_val, "hard_win");
        check_score("score_after_win2");
    endtask

    task automatic test_lose;
        start_game(2'd2);
        for (int i = 0; i < 7; i++) begin
            do_guess((sec_val + 1 + i * 37) % 1000, $sformatf("wrong_%0d", i));
        end
        total++;
        if (lose !== 1'b1 || attempts_left !== 4'd0 || busy !== 1'b0) begin
            $display("FAIL lose_state lose=%b att=%0d busy=%b expected 1/0/0", lose, attempts_left, busy);
        end else passed++;
        check_score("score_after_lose");
        start_game(2'd3);
    endtask

    task automatic test_restart;
        for (int i = 0; i < 4; i++) begin
            do_guess((sec_val + 500 + i) % 1000, $sformatf("pre_abort_%0d", i));
        end
        @(posedge clk);
        #2 restart = 1'b0;
        #1;
        total++;
        if ({max_digits, secret_digit_1, secret_digit_2, secret_digit_3, attempts_left,
             hint_high, hint_low, win, lose, busy, score} !== 33'd0) begin
            $display("FAIL async_restart md=%0d att=%0d busy=%b lose=%b score=%0d expected all 0",
                     max_digits, attempts_left, busy, lose, score);
        end else passed++;
        exp_score = 0;
        @(negedge clk);
        restart = 1'b1;
    endtask

    task automatic test_start_confirm;
        @(negedge clk);
        start = 1'b1; confirm = 1'b1; difficulty = 2'd2;
        drive_digits(0);
        @(negedge clk);
        start = 1'b0; confirm = 1'b0;
        total++;
        if (busy !== 1'b1 || max_digits !== 2'd2) begin
            $display("FAIL start_confirm_gen busy=%b md=%0d expected 1/2", busy, max_digits);
        end else passed++;
        repeat (3) @(negedge clk);
        total++;
        if (attempts_left !== 4'd7 || busy !== 1'b1 || win !== 1'b0 || hint_high !== 1'b0 ||
            hint_low !== 1'b0) begin
            $display("FAIL start_confirm_drop att=%0d busy=%b win=%b hh=%b hl=%b expected 7/1/0/0/0",
                     attempts_left, busy, win, hint_high, hint_low);
        end else passed++;
        check_score("score_after_restart");
    endtask

    initial begin
        test_reset();
        test_easy_win();
        test_hints();
        test_lose();
        test_restart();
        test_start_confirm();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
